gray_stream_ctrl: RTL and testbench

Frame-level sequencer for the RGB444-to-8-bit-gray converter in the camera filter pipeline. It sits between the camera capture stage and the frame-buffer writer. It feeds captured pixels into the two-cycle gray converter and delays sync/valid and bypass data to match the converter latency. It also latches the filter mode only at frame boundaries, counts pixel position, and reports frame completion and geometry errors.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_delay_line.sv | 38 +++
 rtl/gray_stream_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gray_stream_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the RGB444-to-gray stream controller.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam int RGB_W     = 12;
    localparam int GRAY_W    = 8;
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;
    localparam int LAT_DEF   = 2;

    // Per-pixel side information that travels alongside the converter.
    typedef struct packed {
        logic             valid;
        logic             mode;
        logic             sof;
        logic             eol;
        logic [RGB_W-1:0] rgb;
    } pix_t;

    // Gray back onto the 12-bit output bus: upper nibble on every channel.
    function automatic logic [RGB_W-1:0] gray_to_rgb444(input logic [3:0] g_hi);
        return {g_hi, g_hi, g_hi};
    endfunction

endpackage

// File: rtl/gray_delay_line.sv
// Fixed-depth register chain that keeps sideband and bypass data aligned
// with the external gray converter.
module gray_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // NOTE: the whole chain, data included, is cleared asynchronously so a
    // reset mid-frame cannot leave a stale valid bit to emerge after release.
    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                // NOTE: non-blocking so every stage shifts on the same edge.
                stage <= d;
            end
        end
    end else begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                stage <= {stage[DEPTH-2:0], d};
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/gray_stream_ctrl.sv
// Frame sequencer around the external RGB444-to-gray converter.
// Optional per-frame drop counter: define GRAY_DROP_CNT_EN.
module gray_stream_ctrl
    import gray_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gray_en_req,
    input  logic              in_vsync,
    input  logic              in_valid,
    input  logic [RGB_W-1:0]  in_rgb,
    output logic [RGB_W-1:0]  conv_rgb,
    input  logic [GRAY_W-1:0] conv_gray,
    output logic              out_valid,
    output logic [RGB_W-1:0]  out_data,
    output logic              out_sof,
    output logic              out_eol,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              geom_err,
    output logic              gray_active
`ifdef GRAY_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t          state;
    logic            vsync_q;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            sof_pending;
    logic            resync;
    logic [CW-1:0]   flush_cnt;
    pix_t            s0;
    pix_t            dl;

    logic vsync_rise;
    logic vsync_fall;
    logic accept;
    logic eol_now;
    logic last_now;
    logic [3:0] gray_lsb_unused;

    assign vsync_rise = in_vsync && !vsync_q;
    assign vsync_fall = !in_vsync && vsync_q;
    assign accept     = (state == ACTIVE) && in_valid;
    assign eol_now    = (x == XW'(H_ACT - 1));
    assign last_now   = eol_now && (y == YW'(V_ACT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vsync_q     <= 1'b0;
            x           <= '0;
            y           <= '0;
            sof_pending <= 1'b0;
            resync      <= 1'b0;
            flush_cnt   <= '0;
            frame_done  <= 1'b0;
            geom_err    <= 1'b0;
            gray_active <= 1'b0;
        end else begin
            vsync_q    <= in_vsync;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (vsync_rise) state <= SYNC;
                end
                SYNC: begin
                    if (vsync_fall) begin
                        gray_active <= gray_en_req;
                        geom_err    <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        sof_pending <= 1'b1;
                        resync      <= 1'b0;
                        state       <= ACTIVE;
                    end else if (in_valid) begin
                        geom_err <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        sof_pending <= 1'b0;
                        if (eol_now) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                    // A new vsync before the frame completes is a short frame:
                    // drain what is in flight, then wait for its falling edge.
                    if (vsync_rise) begin
                        geom_err  <= 1'b1;
                        resync    <= 1'b1;
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end else if (accept && last_now) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (in_valid) geom_err <= 1'b1;
                    if (vsync_rise) resync <= 1'b1;
                    if (flush_cnt == CW'(LAT - 1)) begin
                        frame_done <= 1'b1;
                        state      <= (resync || vsync_rise) ? SYNC : IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accept stage: this register is also the converter input, so the side
    // information starts its LAT-deep trip on the same edge as conv_rgb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= '0;
        end else begin
            s0.valid <= accept;
            s0.mode  <= gray_active;
            s0.sof   <= accept && sof_pending;
            s0.eol   <= accept && eol_now;
            s0.rgb   <= in_rgb;
        end
    end

    assign conv_rgb = s0.rgb;

    gray_delay_line #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s0),
        .q     (dl)
    );

    assign out_valid = dl.valid;
    assign out_sof   = dl.sof;
    assign out_eol   = dl.eol;

    // NOTE: default assignment first so the mux can never infer a latch.
    always_comb begin
        out_data = '0;
        if (dl.valid) begin
            out_data = dl.mode ? gray_to_rgb444(conv_gray[7:4]) : dl.rgb;
        end
    end

    assign gray_lsb_unused = conv_gray[3:0];

`ifdef GRAY_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (state == SYNC) begin
            drop_cnt <= '0;
        end else if (out_valid && !out_ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic ready_unused;
    assign ready_unused = out_ready;
`endif

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Randomized frame-level bench for gray_stream_ctrl with a queue-based
// reference of expected output pixels and frame_done pulses.
module tb_gray_stream_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gray_en_req = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_rgb = '0;
    logic [11:0] conv_rgb;
    logic [7:0]  conv_gray;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_sof;
    logic        out_eol;
    logic        out_ready = 1'b1;
    logic        frame_done;
    logic        geom_err;
    logic        gray_active;
`ifdef GRAY_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    gray_stream_ctrl #(.H_ACT(H), .V_ACT(V), .LAT(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_en_req (gray_en_req),
        .in_vsync    (in_vsync),
        .in_valid    (in_valid),
        .in_rgb      (in_rgb),
        .conv_rgb    (conv_rgb),
        .conv_gray   (conv_gray),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .geom_err    (geom_err),
        .gray_active (gray_active)
`ifdef GRAY_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] luma(input logic [11:0] p);
        int r, g, b;
        r = int'({p[11:8], p[11:8]});
        g = int'({p[7:4], p[7:4]});
        b = int'({p[3:0], p[3:0]});
        return 8'((77 * r + 150 * g + 29 * b) >> 8);
    endfunction

    // Converter stand-in: LAT registers on conv_rgb, then the luma function.
    logic [11:0] cv1 = '0, cv2 = '0;
    always @(posedge clk) begin
        cv1 <= conv_rgb;
        cv2 <= cv1;
    end
    assign conv_gray = luma(cv2);

    always begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int unsigned due;
        logic [11:0] data;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned done_q[$];
    int          model_drops = 0;
    bit          mon_en = 1'b0;
    bit          pix_due;
    bit          done_due;

    always @(negedge clk) begin
        if (mon_en) begin
            pix_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("out_valid", out_valid, pix_due);
            if (pix_due) begin
                if (out_valid) begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_sof", out_sof, exp_q[0].sof);
                    check("out_eol", out_eol, exp_q[0].eol);
                end
                if (!out_ready) model_drops++;
                void'(exp_q.pop_front());
            end
            done_due = (done_q.size() > 0) && (done_q[0] == cyc);
            check("frame_done", frame_done, done_due);
            if (done_due) void'(done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pixel(input logic [11:0] p, input logic gray,
                              input logic sof, input logic eol);
        exp_t e;
        logic [7:0] g;
        g = luma(p);
        e.due  = cyc + 1 + L;
        e.data = gray ? {g[7:4], g[7:4], g[7:4]} : p;
        e.sof  = sof;
        e.eol  = eol;
        exp_q.push_back(e);
        in_rgb   = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic mode, input int npix, input bit toggle_req,
                             input bit sync_noise, input bit flush_noise, input bit fixed_first);
        bit short_frame;
        logic [11:0] p;
        short_frame = (npix < H * V);
        gray_en_req = mode;
        in_vsync    = 1'b1;
        tick();
        in_valid = sync_noise;
        in_rgb   = 12'($urandom);
        tick();
        in_valid = 1'b0;
        if (sync_noise) check("geom_err_sync_pixel", geom_err, 1);
        tick();
        in_vsync    = 1'b0;
        model_drops = 0;
        tick();
        check("geom_err_frame_start", geom_err, 0);
        check("gray_active_latch", gray_active, mode);
`ifdef GRAY_DROP_CNT_EN
        check("drop_cnt_cleared", drop_cnt, 0);
`endif
        for (int i = 0; i < npix; i++) begin
            if (toggle_req && i == npix / 2) gray_en_req = ~mode;
            repeat ($urandom_range(0, 2)) begin
                in_rgb = 12'($urandom);
                tick();
            end
            p = (fixed_first && i == 0) ? 12'hA5C : 12'($urandom);
            if (i == H * V - 1) done_q.push_back(cyc + 1 + L);
            send_pixel(p, mode, i == 0, (i % H) == H - 1);
        end
        if (short_frame) begin
            repeat ($urandom_range(0, 2)) tick();
            in_vsync = 1'b1;
            done_q.push_back(cyc + 1 + L);
        end else if (flush_noise) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        idle(L + 3);
        check("gray_active_hold", gray_active, mode);
        check("geom_err_frame_end", geom_err, short_frame || flush_noise);
        check("pixels_drained", exp_q.size(), 0);
        check("frame_done_seen", done_q.size(), 0);
`ifdef GRAY_DROP_CNT_EN
        // A short frame lands in SYNC, which clears the counter.
        check("drop_cnt_frame", drop_cnt, short_frame ? 0 : model_drops);
`endif
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_sof"}, out_sof, 0);
        check({tag, "_out_eol"}, out_eol, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_geom_err"}, geom_err, 0);
        check({tag, "_gray_active"}, gray_active, 0);
        check({tag, "_conv_rgb"}, conv_rgb, 0);
`ifdef GRAY_DROP_CNT_EN
        check({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        run_frame(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0);

        // Pixels while idle are dropped without an error.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_rgb   = 12'($urandom);
            tick();
        end
        in_valid = 1'b0;
        idle(L + 2);
        check("geom_err_idle_pixel", geom_err, 0);

        run_frame(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int f = 0; f < 5; f++) begin
            run_frame(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : H * V,
                      1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        // Reset with pixels in flight.
        gray_en_req = 1'b1;
        in_vsync    = 1'b1;
        idle(2);
        in_vsync = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send_pixel(12'($urandom), 1'b1, i == 0, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check_all_zero("midframe_reset");
        idle(2);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_rgb   = 12'($urandom);
            tick();
        end
        in_valid = 1'b0;
        idle(L + 4);
        check("post_reset_gray_active", gray_active, 0);

        run_frame(1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
